// File: rtl/instr_encode_loader_if.sv
// rtl/instr_encode_loader_if.sv - request, memory-write and status bundle for instr_encode_loader
`timescale 1ns/1ps
interface instr_encode_loader_if #(
    parameter int DEPTH = 256
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_class;
    logic [2:0]    funct3;
    logic          funct7b5;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [11:0]   imm;
    logic          seal;
    logic          clear;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [CW-1:0] count;
    logic          full;
    logic          sealed;
    logic          err;

    modport slave (
        input  req_valid, req_class, funct3, funct7b5, rd, rs1, rs2, imm, seal, clear,
        output req_ready, mem_we, mem_addr, mem_wdata, count, full, sealed, err
    );

    modport master (
        output req_valid, req_class, funct3, funct7b5, rd, rs1, rs2, imm, seal, clear,
        input  req_ready, mem_we, mem_addr, mem_wdata, count, full, sealed, err
    );
endinterface

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - encodes RV32I-subset requests and streams them into instruction memory
`timescale 1ns/1ps
module instr_encode_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 rst,
    instr_encode_loader_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_SEALED = 2'd2;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          err_q, err_d;
    logic          seal_pend_q, seal_pend_d;

    logic          full;
    logic          accept;
    logic          legal;
    logic [31:0]   enc_word;
    logic [31:0]   next_addr;

    assign full          = (count_q == CW'(DEPTH));
    assign bus.req_ready = (state_q == S_IDLE) && !full && !bus.seal && !bus.clear;
    assign accept        = bus.req_valid && bus.req_ready;
    assign next_addr     = BASE_ADDR + (32'(count_q) << 2);

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.sealed    = (state_q == S_SEALED);
    assign bus.err       = err_q;

    // Branch imm input carries offset bits [12:1], so imm[11] is offset bit 12.
    always_comb begin
        legal    = 1'b1;
        enc_word = 32'h0;
        case (bus.req_class)
            3'd0: enc_word = {bus.imm, bus.rs1, 3'b010, bus.rd, 7'b0000011};
            3'd1: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
            3'd2: enc_word = {1'b0, bus.funct7b5, 5'b00000, bus.rs2, bus.rs1, bus.funct3,
                              bus.rd, 7'b0110011};
            3'd3: enc_word = {bus.imm, bus.rs1, bus.funct3, bus.rd, 7'b0010011};
            3'd4: enc_word = {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, bus.funct3,
                              bus.imm[3:0], bus.imm[10], 7'b1100011};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        seal_pend_d = seal_pend_q;
        if (bus.clear) begin
            state_d     = S_IDLE;
            count_d     = '0;
            err_d       = 1'b0;
            seal_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.seal) begin
                        if (!full) begin
                            state_d     = S_WRITE;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = next_addr;
                            mem_wdata_d = NOP_WORD;
                            seal_pend_d = 1'b1;
                        end else begin
                            state_d = S_SEALED;
                        end
                    end else if (accept) begin
                        if (legal) begin
                            state_d     = S_WRITE;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = next_addr;
                            mem_wdata_d = enc_word;
                            seal_pend_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    state_d     = seal_pend_q ? S_SEALED : S_IDLE;
                    seal_pend_d = 1'b0;
                    if (!full) begin
                        count_d = count_q + CW'(1);
                    end
                end
                S_SEALED: state_d = S_SEALED;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            err_q       <= 1'b0;
            seal_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            seal_pend_q <= seal_pend_d;
        end
    end
endmodule

// File: doc/instr_encode_loader.md
INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction-memory capacity in 32-bit words (power of two, 2..4096).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  encode request present.
REQ-007 req_ready  output  1  request accepted when req_valid & req_ready at a rising edge.
REQ-008 req_class  input  3  0=LW, 1=SW, 2=R-type ALU, 3=I-type ALU, 4=branch, 5..7 illegal.
REQ-009 funct3  input  3  funct3 for classes 2, 3, 4 (ignored for LW/SW).
REQ-010 funct7b5  input  1  instruction bit 30 for class 2 (ignored otherwise).
REQ-011 rd, rs1, rs2  input  5 each  register indices.
REQ-012 imm  input  12  imm[11:0] for classes 0, 1, 3; imm[12:1] for class 4.
REQ-013 seal  input  1  single-cycle pulse: append a NOP and lock.
REQ-014 clear  input  1  single-cycle pulse: rewind to empty and unlock.
REQ-015 mem_we, mem_addr[31:0], mem_wdata[31:0]  output  instruction-memory write port.
REQ-016 count  output  $clog2(DEPTH)+1  words written.
REQ-017 full, sealed, err  output  1 each  status flags.

Function
REQ-018 Encoding SHALL use opcodes LW 0000011, SW 0100011, R 0110011, I 0010011, branch 1100011.
REQ-019 Field placement SHALL be: LW/I = imm[11:0]|rs1|f3|rd|op; SW = imm[11:5]|rs2|rs1|f3|imm[4:0]|op; R = {0,funct7b5,00000}|rs2|rs1|f3|rd|op; branch = imm12|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm11|op.
REQ-020 LW and SW SHALL force funct3=010.
REQ-021 Latency SHALL be fixed: a request accepted at edge N SHALL drive mem_we=1 for exactly the cycle after edge N.
REQ-022 In that cycle, mem_addr SHALL be BASE_ADDR+4*count(before increment); count SHALL increment at edge N+1.
REQ-023 req_ready SHALL be combinational: state==IDLE & !full & !seal & !clear.
REQ-024 FSM states SHALL be IDLE, WRITE (one cycle) and SEALED; IDLE->WRITE on accept, WRITE->IDLE otherwise.
REQ-025 seal in IDLE & !full SHALL write 32'h0000_0013 through WRITE with the same latency, then enter SEALED.
REQ-026 seal when full SHALL enter SEALED directly without writing.
REQ-027 seal SHALL be ignored in WRITE or SEALED.
REQ-028 req_valid and seal asserted together SHALL give seal priority; the request SHALL NOT be accepted.
REQ-029 full SHALL equal (count==DEPTH); count SHALL saturate at DEPTH and never wrap.
REQ-030 An illegal req_class SHALL be accepted (ready handshake completes), SHALL produce no write, and SHALL set sticky err.
REQ-031 clear SHALL, at the next edge and from any state, set count=0, state=IDLE, err=0, sealed=0, mem_we=0; clear SHALL override seal and requests.
REQ-032 clear during WRITE SHALL NOT suppress that cycle's in-flight write.
REQ-033 sealed SHALL be 1 exactly in SEALED.

Reset
REQ-034 rst low SHALL immediately force state=IDLE, count=0, mem_we=0, mem_addr=0, mem_wdata=0, full=0, sealed=0, err=0.
REQ-035 rst asserted mid-WRITE SHALL abort the write (mem_we low asynchronously).
REQ-036 The first request SHALL be accepted no earlier than the first edge after rst deasserts.

Verification
REQ-037 class 2, f3=0, b5=0, rd=3, rs1=1, rs2=2 -> next cycle mem_we=1, addr=0x0, wdata=0x002081B3; with b5=1 -> 0x402081B3.
REQ-038 LW rd=5, rs1=2, imm=8 -> 0x00812283; SW rs2=6, rs1=2, imm=12 -> 0x00612623; branch rs1=1, rs2=2, f3=0, imm=4 -> 0x00208463.
REQ-039 Back-to-back valid with DEPTH=4 -> writes at addresses 0, 4, 8, 12 on alternate cycles; then full=1, req_ready=0, count=4.
REQ-040 seal with count=2 -> NOP 0x00000013 written at address 8, then sealed=1, count=3, req_ready stuck at 0 until clear.
REQ-041 req_class=6 -> no mem_we, err=1 held; clear -> err=0, count=0.
REQ-042 rst pulse during WRITE -> mem_we drops without a clock edge, all outputs 0, and a post-reset request writes to address 0.
